// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: owns the IR, execute sub-state, PC-increment
// timing, retired-instruction count, halt and step-overrun fault.
module instr_sequencer #(
    parameter logic [10:0] HALT_OPC  = 11'h7FF,
    parameter int unsigned MAX_STEPS = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             run,
    input  logic [31:0]      instr_in,
    input  logic             mem_ready,
    input  logic             stall,
    input  logic [1:0]       dec_next_state,
    output logic             fetch_req,
    output logic [31:0]      ir,
    output logic [1:0]       state,
    output logic             exec_en,
    output logic             pc_inc,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } phase_e;

    localparam logic [2:0] MAX_STEP_C = 3'(MAX_STEPS);

    phase_e           phase_q, phase_d;
    logic [31:0]      ir_q, ir_d;
    logic [1:0]       state_q, state_d;
    logic [2:0]       step_q, step_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= IDLE;
            ir_q    <= '0;
            state_q <= '0;
            step_q  <= '0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            ir_q    <= ir_d;
            state_q <= state_d;
            step_q  <= step_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        ir_d    = ir_q;
        state_d = state_q;
        step_d  = step_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        unique case (phase_q)
            IDLE: begin
                if (run) phase_d = FETCH;
            end
            FETCH: begin
                if (mem_ready) begin
                    ir_d    = instr_in;
                    state_d = 2'b00;
                    step_d  = 3'd1;
                    // Halt word is latched but never executed or counted.
                    phase_d = (instr_in[31:21] == HALT_OPC) ? HALT : EXEC;
                end else if (!run) begin
                    phase_d = IDLE;
                end
            end
            EXEC: begin
                if (!stall) begin
                    if (dec_next_state == 2'b00) begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = 2'b00;
                        phase_d = run ? FETCH : IDLE;
                    end else if (step_q == MAX_STEP_C) begin
                        fault_d = 1'b1;
                        phase_d = HALT;
                    end else begin
                        state_d = dec_next_state;
                        step_d  = step_q + 3'd1;
                    end
                end
            end
            HALT: begin
                phase_d = HALT;
            end
            default: begin
                phase_d = IDLE;
            end
        endcase
    end

    assign fetch_req   = (phase_q == FETCH);
    assign exec_en     = (phase_q == EXEC) & ~stall;
    assign pc_inc      = exec_en & (dec_next_state == 2'b00);
    assign halted      = (phase_q == HALT);
    assign fault       = fault_q;
    assign ir          = ir_q;
    assign state       = state_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: vector table plus reset/halt/wrap sequences.
module tb_instr_sequencer;

    localparam logic [31:0] MOVZ = 32'hD2800041;
    localparam logic [31:0] MOVK = 32'hF2800041;
    localparam logic [31:0] ODD  = 32'h12345678;
    localparam logic [31:0] HLTW = 32'hFFE00000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        run, mem_ready, stall;
    logic [31:0] instr_in;
    logic [1:0]  dns;

    logic        fr1, ee1, pi1, hl1, ft1;
    logic [31:0] ir1;
    logic [1:0]  st1;
    logic [15:0] cnt1;

    logic        fr2, ee2, pi2, hl2, ft2;
    logic [31:0] ir2;
    logic [1:0]  st2;
    logic [1:0]  cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    instr_sequencer dut (
        .clock(clock), .reset_n(reset_n), .run(run),
        .instr_in(instr_in), .mem_ready(mem_ready), .stall(stall),
        .dec_next_state(dns), .fetch_req(fr1), .ir(ir1), .state(st1),
        .exec_en(ee1), .pc_inc(pi1), .halted(hl1), .fault(ft1),
        .instr_count(cnt1)
    );

    instr_sequencer #(.CNT_W(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .run(run),
        .instr_in(instr_in), .mem_ready(mem_ready), .stall(stall),
        .dec_next_state(dns), .fetch_req(fr2), .ir(ir2), .state(st2),
        .exec_en(ee2), .pc_inc(pi2), .halted(hl2), .fault(ft2),
        .instr_count(cnt2)
    );

    typedef struct {
        logic        run, mr, stall;
        logic [31:0] instr;
        logic [1:0]  dns;
        logic        fr, ee, pi, hl, ft;
        logic [1:0]  st;
        logic [15:0] cnt;
        logic [31:0] ir;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(
        logic r, logic m, logic s, logic [31:0] in, logic [1:0] d,
        logic fr, logic ee, logic pi, logic hl, logic ft,
        logic [1:0] st, logic [15:0] cnt, logic [31:0] irv);
        vec_t v;
        v.run = r; v.mr = m; v.stall = s; v.instr = in; v.dns = d;
        v.fr = fr; v.ee = ee; v.pi = pi; v.hl = hl; v.ft = ft;
        v.st = st; v.cnt = cnt; v.ir = irv;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " fetch_req"}, 32'(fr1), 0);
        chk({tag, " exec_en"}, 32'(ee1), 0);
        chk({tag, " pc_inc"}, 32'(pi1), 0);
        chk({tag, " halted"}, 32'(hl1), 0);
        chk({tag, " fault"}, 32'(ft1), 0);
        chk({tag, " ir"}, ir1, 0);
        chk({tag, " state"}, 32'(st1), 0);
        chk({tag, " count"}, 32'(cnt1), 0);
        chk({tag, " count2"}, 32'(cnt2), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = mk(1,0,0,0,   0, 0,0,0,0,0, 0,0,0);
        vecs[1]  = mk(1,1,0,MOVZ,0, 1,0,0,0,0, 0,0,0);
        vecs[2]  = mk(1,0,0,0,   0, 0,1,1,0,0, 0,0,MOVZ);
        vecs[3]  = mk(1,1,0,MOVK,0, 1,0,0,0,0, 0,1,MOVZ);
        vecs[4]  = mk(1,0,0,0,   1, 0,1,0,0,0, 0,1,MOVK);
        vecs[5]  = mk(1,0,1,0,   0, 0,0,0,0,0, 1,1,MOVK);
        vecs[6]  = mk(1,0,1,0,   0, 0,0,0,0,0, 1,1,MOVK);
        vecs[7]  = mk(1,0,1,0,   0, 0,0,0,0,0, 1,1,MOVK);
        vecs[8]  = mk(1,0,0,0,   0, 0,1,1,0,0, 1,1,MOVK);
        vecs[9]  = mk(1,0,0,0,   0, 1,0,0,0,0, 0,2,MOVK);
        vecs[10] = mk(0,1,0,MOVZ,0, 1,0,0,0,0, 0,2,MOVK);
        vecs[11] = mk(0,0,0,0,   0, 0,1,1,0,0, 0,2,MOVZ);
        vecs[12] = mk(0,0,0,0,   0, 0,0,0,0,0, 0,3,MOVZ);
        vecs[13] = mk(1,0,0,0,   0, 0,0,0,0,0, 0,3,MOVZ);
        vecs[14] = mk(0,0,0,0,   0, 1,0,0,0,0, 0,3,MOVZ);
        vecs[15] = mk(1,0,0,0,   0, 0,0,0,0,0, 0,3,MOVZ);
        vecs[16] = mk(1,1,0,ODD, 1, 1,0,0,0,0, 0,3,MOVZ);
        vecs[17] = mk(1,0,0,0,   1, 0,1,0,0,0, 0,3,ODD);
        vecs[18] = mk(1,0,0,0,   1, 0,1,0,0,0, 1,3,ODD);
        vecs[19] = mk(1,0,0,0,   1, 0,1,0,0,0, 1,3,ODD);
        vecs[20] = mk(1,0,0,0,   1, 0,1,0,0,0, 1,3,ODD);
        vecs[21] = mk(1,0,0,0,   1, 0,0,0,1,1, 1,3,ODD);
        vecs[22] = mk(0,0,0,0,   1, 0,0,0,1,1, 1,3,ODD);

        reset_n = 1'b0; run = 0; mem_ready = 0; stall = 0;
        instr_in = '0; dns = '0;
        #3 chk_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            run = vecs[i].run; mem_ready = vecs[i].mr;
            stall = vecs[i].stall; instr_in = vecs[i].instr;
            dns = vecs[i].dns;
            #1;
            chk($sformatf("v%0d fetch_req", i), 32'(fr1), 32'(vecs[i].fr));
            chk($sformatf("v%0d exec_en", i), 32'(ee1), 32'(vecs[i].ee));
            chk($sformatf("v%0d pc_inc", i), 32'(pi1), 32'(vecs[i].pi));
            chk($sformatf("v%0d halted", i), 32'(hl1), 32'(vecs[i].hl));
            chk($sformatf("v%0d fault", i), 32'(ft1), 32'(vecs[i].ft));
            chk($sformatf("v%0d state", i), 32'(st1), 32'(vecs[i].st));
            chk($sformatf("v%0d count", i), 32'(cnt1), 32'(vecs[i].cnt));
            chk($sformatf("v%0d count2", i), 32'(cnt2),
                32'(vecs[i].cnt[1:0]));
            chk($sformatf("v%0d ir", i), ir1, vecs[i].ir);
            @(negedge clock);
        end

        // Halt opcode: latched, never executed, absorbing.
        reset_n = 1'b0; run = 1; mem_ready = 0; stall = 0;
        instr_in = '0; dns = '0;
        #1 chk_zero("reset2");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        mem_ready = 1; instr_in = HLTW;
        #1 chk("halt fetch_req", 32'(fr1), 1);
        @(negedge clock);
        mem_ready = 0; instr_in = '0;
        #1;
        chk("halt halted", 32'(hl1), 1);
        chk("halt fetch_req0", 32'(fr1), 0);
        chk("halt exec_en", 32'(ee1), 0);
        chk("halt ir", ir1, HLTW);
        chk("halt count", 32'(cnt1), 0);
        chk("halt fault", 32'(ft1), 0);
        run = 0;
        @(negedge clock);
        #1 chk("halt run0", 32'(hl1), 1);
        run = 1; mem_ready = 1;
        @(negedge clock);
        #1;
        chk("halt run1", 32'(hl1), 1);
        chk("halt run1 fetch", 32'(fr1), 0);

        // Counter wrap on the 2-bit instance, then async reset mid-EXEC.
        reset_n = 1'b0; run = 1; mem_ready = 1; stall = 0;
        instr_in = MOVZ; dns = '0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            #1 chk($sformatf("wrap%0d pc_inc", k), 32'(pi1), 1);
            @(negedge clock);
            #1;
            chk($sformatf("wrap%0d count", k), 32'(cnt1), 32'(k));
            chk($sformatf("wrap%0d count2", k), 32'(cnt2), 32'(k % 4));
        end
        instr_in = MOVK; dns = 2'b01;
        @(negedge clock);
        @(negedge clock);
        #1 chk("mid state", 32'(st1), 1);
        #2 reset_n = 1'b0;
        #1 chk_zero("async");
        @(negedge clock);
        #1 chk_zero("held");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle control sequencer for the single-datapath CPU.
- Fetches each instruction into an instruction register and drives the 2-bit `state` input of the per-class decoders.
- Steps through the decoders' `nextState` chain until it returns 00 (e.g. MOVK: 00 -> 01 -> 00), then retires the instruction and fetches again.
- Sits between instruction memory and the decoder/control-word mux. It owns the IR, the execute sub-state, PC-increment timing, halt and fault.

Parameters:
- HALT_OPC, 11'h7FF, value of instr[31:21] that halts the machine.
- MAX_STEPS, 4, maximum execute cycles per instruction before a fault is declared (range 1-4).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  level; allows the sequencer to leave IDLE and start fetches.
- instr_in  in  32  instruction word from instruction memory.
- mem_ready  in  1  instruction memory has valid instr_in this cycle.
- stall  in  1  freezes EXEC in its current sub-state (datapath/RAM busy).
- dec_next_state  in  2  nextState from the active decoder; 00 = instruction complete.
- fetch_req  out  1  request instruction read; high in FETCH.
- ir  out  32  registered instruction presented to the decoders.
- state  out  2  execute sub-state presented to the decoders.
- exec_en  out  1  control word valid; gates regW/ramW, high in EXEC when stall=0.
- pc_inc  out  1  one-cycle pulse in the final EXEC cycle of an instruction.
- halted  out  1  high in HALT.
- fault  out  1  sticky; step overrun occurred.
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.

Behaviour:
- FSM states: IDLE, FETCH, EXEC, HALT.
- Reset (asynchronous, while reset_n=0):
  - phase=IDLE; ir=0; state=00; step=0; fault=0; instr_count=0.
  - All outputs low or zero.
- Decoded outputs:
  - fetch_req = (phase==FETCH).
  - exec_en = (phase==EXEC) & ~stall.
  - pc_inc = exec_en & (dec_next_state==00).
  - halted = (phase==HALT).
- IDLE:
  - run=1 -> FETCH next cycle.
  - Otherwise stay in IDLE.
- FETCH, mem_ready=1:
  - ir <= instr_in; state <= 00; step <= 1.
  - instr_in[31:21]==HALT_OPC -> HALT. ir is still loaded; no EXEC cycle; not counted.
  - Otherwise -> EXEC.
- FETCH, mem_ready=0:
  - run=0 -> IDLE.
  - run=1 -> stay in FETCH.
  - A transaction already accepted (mem_ready=1) always completes regardless of run.
- EXEC, stall=1:
  - Hold all registers; exec_en=0, pc_inc=0.
- EXEC, stall=0, dec_next_state==00:
  - Retire: instr_count <= instr_count+1; state <= 00.
  - run=1 -> FETCH; run=0 -> IDLE.
- EXEC, stall=0, dec_next_state!=00:
  - step==MAX_STEPS -> fault <= 1, phase -> HALT, no retire, no pc_inc.
  - Otherwise state <= dec_next_state; step <= step+1; stay in EXEC.
- HALT is absorbing; only reset_n exits it. fault is cleared only by reset.
- Latency:
  - Single-step instruction: fetch accept -> exec 1 cycle -> next fetch_req. Minimum 2 cycles per instruction.
  - N-step instruction: N+1 cycles, plus any stall and memory-wait cycles.
- run is sampled only at IDLE exit, at a FETCH wait and at retirement. Deasserting run mid-instruction finishes that instruction.
- Reset asserted mid-EXEC:
  - Aborts immediately: no retire, count unchanged from reset value 0.
  - Outputs go to reset values asynchronously.
- Counter wrap: all-ones + 1 -> 0, with no flag.

Test Plan:
- Reset, then run=1, mem_ready=1, instr_in=32'hD2800041 (MOVZ X1,#2), dec_next_state=00 -> FETCH then one EXEC cycle; exec_en=1, pc_inc=1, state=00, instr_count=1.
- MOVK instr 32'hF2800041, dec_next_state 01 then 00 -> state 00 then 01 over two exec_en cycles; pc_inc only in the second; instr_count +1.
- stall=1 for 3 cycles during MOVK step 01 -> state held at 01, exec_en=0, pc_inc=0 for those cycles, then normal completion.
- dec_next_state stuck at 01 with MAX_STEPS=4 -> after 4 exec cycles fault=1, halted=1, no pc_inc, count unchanged.
- instr_in[31:21]=11'h7FF -> halted=1 the cycle after accept, fetch_req=0; remains halted with run toggled.
- CNT_W=2, 5 single-step instructions -> instr_count 1,2,3,0,1. Then reset_n pulsed low mid-EXEC -> all outputs 0 asynchronously, phase IDLE.
